// File: rtl/code_to_thermo_dec_pkg.sv
// Shared constants, buffer state encoding and the code-to-thermometer helper
// for the code_to_thermo_dec block.
package code_to_thermo_dec_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int MAX_WIDTH = 64;
   localparam int CODE_NONE = WIDTH_DEF;
   localparam int CODE_ALL  = 0;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

   function automatic int cw_of(input int w);
      return $clog2(w) + 1;
   endfunction

   // Bit i is set iff i >= code; callers size-cast down to their pattern width.
   function automatic logic [MAX_WIDTH-1:0] thermo_of(input int unsigned code);
      logic [MAX_WIDTH-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         p[i] = (i >= code);
      end
      return p;
   endfunction

endpackage

// File: rtl/code_to_thermo_dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; head entry drives out_data,
// in_ready is registered so it never depends on out_ready combinationally.
module dec_skid_buf
   import code_to_thermo_dec_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   buf_state_t    state;
   logic [DW-1:0] tail;
   logic          push;
   logic          pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= BUF_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         tail      <= '0;
      end else begin
         case (state)
            BUF_EMPTY: begin
               if (push) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (push && pop) begin
                  out_data <= in_data;
               end else if (push) begin
                  tail     <= in_data;
                  in_ready <= 1'b0;
                  state    <= BUF_FULL;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  state     <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               // in_ready is low here, so only a drain can happen.
               if (pop) begin
                  out_data <= tail;
                  in_ready <= 1'b1;
                  state    <= BUF_ONE;
               end
            end
            default: begin
               state     <= BUF_EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/code_to_thermo_dec.sv
// Registered leading-ones code to canonical pattern decoder on a valid/ready stream.
// Define DEC_ERR_EN to drop illegal codes and flag them on a sticky err output.
module code_to_thermo_dec
   import code_to_thermo_dec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   localparam int CW   = cw_of(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    code_in,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef DEC_ERR_EN
   output logic             err,
   input  logic             err_clr,
`endif
   output logic [WIDTH-1:0] pattern_out
);

   logic             legal;
   logic             buf_valid;
   logic [CW-1:0]    code_eff;
   logic [WIDTH-1:0] pattern_nxt;

   assign legal       = (code_in <= CW'(WIDTH));
   assign pattern_nxt = WIDTH'(thermo_of(32'(code_eff)));

`ifdef DEC_ERR_EN
   // Illegal codes still complete the handshake but never reach the buffer.
   assign code_eff  = code_in;
   assign buf_valid = in_valid && legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              err <= 1'b0;
      else if (in_valid && in_ready && !legal) err <= 1'b1;
      else if (err_clr)                       err <= 1'b0;
   end
`else
   assign code_eff  = legal ? code_in : CW'(WIDTH);
   assign buf_valid = in_valid;
`endif

   dec_skid_buf #(
      .DW (WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (buf_valid),
      .in_ready  (in_ready),
      .in_data   (pattern_nxt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (pattern_out)
   );

endmodule
